// File: rtl/nandgate_monitor.sv
// Checks a NAND gate under test: each accepted vector (a, b, c) is compared against
// ~(a & b) one cycle later, and per-session pass/fail statistics are accumulated.
module nandgate_monitor #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_flag,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_mask
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]   TOT_ONE = (CNT_W+1)'(1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_num_vec;
    logic [CNT_W-1:0] r_acc_cnt;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic [CNT_W-1:0] r_err_idx;
    logic [CNT_W-1:0] r_pipe_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] r_err_mask;
    logic             r_pipe_vld;
    logic             r_err_flag;

    logic             w_start_ok;
    logic             w_accept;
    logic [WIDTH-1:0] w_mask;
    logic             w_mismatch;
    logic [CNT_W:0]   w_total_next;
    logic             w_last_cmp;

    assign w_start_ok   = start && (r_state != RUN);
    assign in_ready     = (r_state == RUN) && (r_acc_cnt < r_num_vec);
    assign w_accept     = in_valid && in_ready;
    assign w_mask       = r_c ^ ~(r_a & r_b);
    assign w_mismatch   = |w_mask;
    // Count including the compare happening this cycle; one bit wider so it cannot wrap.
    assign w_total_next = {1'b0, r_pass_cnt} + {1'b0, r_fail_cnt} + TOT_ONE;
    assign w_last_cmp   = r_pipe_vld && (w_total_next == {1'b0, r_num_vec});

    assign busy           = (r_state == RUN);
    assign done           = (r_state == DONE);
    assign pass_cnt       = r_pass_cnt;
    assign fail_cnt       = r_fail_cnt;
    assign err_flag       = r_err_flag;
    assign first_err_idx  = r_err_idx;
    assign first_err_mask = r_err_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next = (num_vec == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last_cmp) begin
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Capture stage plus compare stage; a new session wipes any leftover state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_vec  <= '0;
            r_acc_cnt  <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_err_idx  <= '0;
            r_err_mask <= '0;
            r_err_flag <= 1'b0;
            r_pipe_vld <= 1'b0;
            r_pipe_idx <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
        end else if (w_start_ok) begin
            r_num_vec  <= num_vec;
            r_acc_cnt  <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_err_idx  <= '0;
            r_err_mask <= '0;
            r_err_flag <= 1'b0;
            r_pipe_vld <= 1'b0;
        end else begin
            r_pipe_vld <= w_accept;
            if (w_accept) begin
                r_a        <= a;
                r_b        <= b;
                r_c        <= c;
                r_pipe_idx <= r_acc_cnt;
                r_acc_cnt  <= r_acc_cnt + CNT_ONE;
            end
            if (r_pipe_vld) begin
                if (w_mismatch) begin
                    r_fail_cnt <= r_fail_cnt + CNT_ONE;
                    if (!r_err_flag) begin
                        r_err_flag <= 1'b1;
                        r_err_idx  <= r_pipe_idx;
                        r_err_mask <= w_mask;
                    end
                end else begin
                    r_pass_cnt <= r_pass_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_nandgate_monitor.sv
// Randomized scoreboard bench for nandgate_monitor: stimulus pushes expected compare
// results, a monitor pops them as the DUT counters advance, sessions are summarised by a model.
module tb_nandgate_monitor;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    typedef struct {
        logic        isFail;
        logic [31:0] mask;
        int          idx;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] numVec;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] passCnt;
    logic [CNT_W-1:0] failCnt;
    logic             errFlag;
    logic [CNT_W-1:0] firstErrIdx;
    logic [WIDTH-1:0] firstErrMask;

    int          nChecks = 0;
    int          nFails  = 0;
    exp_t        sbQ[$];
    logic [31:0] vA[$];
    logic [31:0] vB[$];
    logic [31:0] vC[$];

    int          prevTotal = 0;
    int          curTotal;
    int          expPass = 0;
    int          expFail = 0;
    logic        expErr  = 1'b0;
    int          expIdx  = 0;
    logic [31:0] expMask = '0;
    exp_t        popped;

    nandgate_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .num_vec        (numVec),
        .in_valid       (inValid),
        .in_ready       (inReady),
        .a              (a),
        .b              (b),
        .c              (c),
        .busy           (busy),
        .done           (done),
        .pass_cnt       (passCnt),
        .fail_cnt       (failCnt),
        .err_flag       (errFlag),
        .first_err_idx  (firstErrIdx),
        .first_err_mask (firstErrMask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every time the DUT's compare count advances, pop the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prevTotal = 0;
            end else begin
                curTotal = int'(passCnt) + int'(failCnt);
                if (curTotal == 0) begin
                    expPass = 0;
                    expFail = 0;
                    expErr  = 1'b0;
                end else if (curTotal == prevTotal + 1) begin
                    if (sbQ.size() == 0) begin
                        checkOutput("sb_unexpected_result", 32'(curTotal), 32'(prevTotal));
                    end else begin
                        popped = sbQ.pop_front();
                        if (popped.isFail) begin
                            expFail++;
                            if (!expErr) begin
                                expErr  = 1'b1;
                                expIdx  = popped.idx;
                                expMask = popped.mask;
                            end
                        end else begin
                            expPass++;
                        end
                        checkOutput("sb_pass_cnt", 32'(passCnt), 32'(expPass));
                        checkOutput("sb_fail_cnt", 32'(failCnt), 32'(expFail));
                        checkOutput("sb_err_flag", 32'(errFlag), 32'(expErr));
                        if (expErr) begin
                            checkOutput("sb_first_err_idx", 32'(firstErrIdx), 32'(expIdx));
                            checkOutput("sb_first_err_mask", firstErrMask, expMask);
                        end
                    end
                end else if (curTotal != prevTotal) begin
                    checkOutput("sb_count_jump", 32'(curTotal), 32'(prevTotal));
                end
                prevTotal = curTotal;
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(inReady), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_pass_cnt"}, 32'(passCnt), 0);
        checkOutput({tag, "_fail_cnt"}, 32'(failCnt), 0);
        checkOutput({tag, "_err_flag"}, 32'(errFlag), 0);
        checkOutput({tag, "_first_err_idx"}, 32'(firstErrIdx), 0);
        checkOutput({tag, "_first_err_mask"}, firstErrMask, 0);
    endtask

    task automatic addVec(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vc);
        vA.push_back(va);
        vB.push_back(vb);
        vC.push_back(vc);
    endtask

    task automatic randomVectors(input int n);
        logic [31:0] ra, rb, rc;
        vA.delete(); vB.delete(); vC.delete();
        for (int i = 0; i < n; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = ~(ra & rb);
            if ($urandom_range(0, 2) == 0) rc = rc ^ (32'h1 << $urandom_range(0, 31));
            addVec(ra, rb, rc);
        end
    endtask

    // Runs one session over vA/vB/vC and checks the final summary against a plain model.
    task automatic applyStimulus(input int n, input bit randValid, input bit injectStart);
        int          acc = 0;
        int          cyc = 0;
        bit          injected = 0;
        int          mPass = 0;
        int          mFail = 0;
        int          mIdx = 0;
        logic [31:0] mMask = '0;
        logic [31:0] m;
        exp_t        e;

        for (int i = 0; i < n; i++) begin
            m = vC[i] ^ ~(vA[i] & vB[i]);
            if (m != 0) begin
                if (mFail == 0) begin
                    mIdx  = i;
                    mMask = m;
                end
                mFail++;
            end else begin
                mPass++;
            end
        end

        @(negedge clk);
        start  = 1'b1;
        numVec = CNT_W'(n);
        @(negedge clk);
        start = 1'b0;
        #1;
        if (n == 0) begin
            checkOutput("zero_done_next_cycle", 32'(done), 1);
            checkOutput("zero_busy", 32'(busy), 0);
        end else begin
            checkOutput("start_busy", 32'(busy), 1);
            checkOutput("start_done_cleared", 32'(done), 0);
        end

        while (acc < n && cyc < 400) begin
            if (injectStart && acc == 1 && !injected) begin
                start    = 1'b1;
                numVec   = '0;
                injected = 1;
            end else begin
                start  = 1'b0;
                numVec = CNT_W'(n);
            end
            inValid = randValid ? 1'($urandom_range(0, 1)) : 1'b1;
            a = vA[acc];
            b = vB[acc];
            c = vC[acc];
            #1;
            if (inValid && inReady) begin
                m    = c ^ ~(a & b);
                e.isFail = (m != 0);
                e.mask   = m;
                e.idx    = acc;
                sbQ.push_back(e);
                acc++;
            end
            @(negedge clk);
            cyc++;
        end
        start   = 1'b0;
        inValid = 1'b0;
        if (acc < n) checkOutput("accept_timeout", 32'(acc), 32'(n));

        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        #2;
        checkOutput("end_done", 32'(done), 1);
        checkOutput("end_busy", 32'(busy), 0);
        checkOutput("end_in_ready", 32'(inReady), 0);
        checkOutput("end_pass_cnt", 32'(passCnt), 32'(mPass));
        checkOutput("end_fail_cnt", 32'(failCnt), 32'(mFail));
        checkOutput("end_err_flag", 32'(errFlag), 32'(mFail != 0));
        checkOutput("end_first_err_idx", 32'(firstErrIdx), 32'(mIdx));
        checkOutput("end_first_err_mask", firstErrMask, mMask);

        inValid = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checkOutput("idle_valid_pass_frozen", 32'(passCnt), 32'(mPass));
        checkOutput("idle_valid_fail_frozen", 32'(failCnt), 32'(mFail));
        checkOutput("idle_valid_done_held", 32'(done), 1);
        inValid = 1'b0;
        checkOutput("sb_drained", 32'(sbQ.size()), 0);
    endtask

    task automatic resetMidSession();
        int acc = 0;
        int cyc = 0;
        randomVectors(6);
        @(negedge clk);
        start  = 1'b1;
        numVec = CNT_W'(6);
        @(negedge clk);
        start = 1'b0;
        while (acc < 3 && cyc < 100) begin
            inValid = 1'($urandom_range(0, 1));
            a = vA[acc]; b = vB[acc]; c = vC[acc];
            #1;
            if (inValid && inReady) begin
                sbQ.push_back('{isFail: (c != ~(a & b)), mask: c ^ ~(a & b), idx: acc});
                acc++;
            end
            @(negedge clk);
            cyc++;
        end
        #3;
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        sbQ.delete();
        inValid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checkAllZero("after_release_idle");
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        numVec  = '0;
        inValid = 1'b0;
        a = '0; b = '0; c = '0;
        #3;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        vA.delete(); vB.delete(); vC.delete();
        addVec(32'h0, 32'h0, 32'hFFFFFFFF);
        addVec(32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF);
        addVec(32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        addVec(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
        applyStimulus(4, 0, 0);

        vA.delete(); vB.delete(); vC.delete();
        addVec(32'h12345678, 32'h0F0F0F0F, ~(32'h12345678 & 32'h0F0F0F0F));
        addVec(32'h0, 32'h007FA509, 32'hFFFFFFFE);
        addVec(32'hAAAA5555, 32'hFFFF0000, ~(32'hAAAA5555 & 32'hFFFF0000));
        applyStimulus(3, 0, 0);

        vA.delete(); vB.delete(); vC.delete();
        addVec(32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFEF);
        addVec(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000);
        applyStimulus(2, 0, 0);

        vA.delete(); vB.delete(); vC.delete();
        applyStimulus(0, 0, 0);

        randomVectors(5);
        applyStimulus(5, 1, 1);

        for (int s = 0; s < 6; s++) begin
            int n = $urandom_range(1, 10);
            randomVectors(n);
            applyStimulus(n, s[0], 0);
        end

        resetMidSession();

        randomVectors(4);
        applyStimulus(4, 1, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
